ldtu_gain_sel_ctrl: RTL and testbench

- Gain-selection controller that sequences the LiTe-DTU input FIFO datapath.
- Each CLK it takes the look-ahead saturation flag from the x10 channel and decides whether the transmitted sample is gain x10 or gain x1.
- It also tells the datapath which look-ahead offset to use for the reference sample.
- It replaces the shift-register window with an explicit FSM plus hold counter, and adds switch telemetry for slow control.

---
 rtl/ldtu_pkg.sv | 32 +++
 rtl/ldtu_sat_counter.sv | 31 +++
 rtl/ldtu_gain_sel_ctrl.sv | 137 +++++++++++++
 tb/tb_ldtu_gain_sel_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ldtu_pkg.sv
// ldtu_pkg: definitions shared by the LiTe-DTU iFIFO datapath and the
// gain-selection controller.
//   - gain_mode_e  : GAIN_SEL_MODE encodings
//   - gain_state_e : gain-selection FSM state encoding (readable as state_dbg)
//   - DEF_WIN_* / DEF_REF_OFS_* : default hold windows and look-ahead offsets
//   - is_g1()      : states in which the x1 sample is transmitted
package ldtu_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO8     = 2'b00,
        MODE_AUTO16    = 2'b01,
        MODE_FORCE_G10 = 2'b10,
        MODE_FORCE_G1  = 2'b11
    } gain_mode_e;

    typedef enum logic [1:0] {
        ST_AUTO_G10  = 2'b00,
        ST_AUTO_G1   = 2'b01,
        ST_FORCE_G10 = 2'b10,
        ST_FORCE_G1  = 2'b11
    } gain_state_e;

    localparam int unsigned DEF_WIN_SHORT     = 8;
    localparam int unsigned DEF_WIN_LONG      = 16;
    localparam int unsigned DEF_REF_OFS_SHORT = 3;
    localparam int unsigned DEF_REF_OFS_LONG  = 5;

    function automatic logic is_g1(input gain_state_e st);
        return (st == ST_AUTO_G1) || (st == ST_FORCE_G1);
    endfunction

endpackage

// File: rtl/ldtu_sat_counter.sv
// ldtu_sat_counter: up-counter that sticks at all-ones, with synchronous clear.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (highest priority)
//   clr_i  : synchronous clear; overrides a simultaneous increment
//   inc_i  : count enable
//   cnt_o  : current count
module ldtu_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ldtu_gain_sel_ctrl.sv
// ldtu_gain_sel_ctrl: gain-selection controller for the LiTe-DTU input FIFO.
// Decides each cycle whether the x10 or x1 sample is transmitted, using the
// x10 look-ahead saturation flag, a hold window and the slow-control mode.
//   CLK           : clock
//   reset         : synchronous active-high reset
//   GAIN_SEL_MODE : 00 auto/short, 01 auto/long, 10 force x10, 11 force x1
//   ref_sat       : x10 reference sample saturated (from datapath)
//   cnt_clr       : clear both telemetry counters
//   sel_g1        : 1 = transmit x1 sample
//   ref_ofs       : look-ahead offset for the datapath reference pointer
//   gain_switch   : one-cycle pulse when sel_g1 changes
//   sat_events    : count of AUTO_G10 -> AUTO_G1 entries (saturating)
//   g1_cycles     : count of cycles with sel_g1 = 1 (saturating)
//   state_dbg     : FSM state encoding
module ldtu_gain_sel_ctrl
    import ldtu_pkg::*;
#(
    parameter int unsigned WIN_SHORT     = DEF_WIN_SHORT,
    parameter int unsigned WIN_LONG      = DEF_WIN_LONG,
    parameter int unsigned REF_OFS_SHORT = DEF_REF_OFS_SHORT,
    parameter int unsigned REF_OFS_LONG  = DEF_REF_OFS_LONG,
    parameter int unsigned NBITS_WIN     = 5,
    parameter int unsigned NBITS_EVT     = 16
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [1:0]           GAIN_SEL_MODE,
    input  logic                 ref_sat,
    input  logic                 cnt_clr,
    output logic                 sel_g1,
    output logic [2:0]           ref_ofs,
    output logic                 gain_switch,
    output logic [NBITS_EVT-1:0] sat_events,
    output logic [NBITS_EVT-1:0] g1_cycles,
    output logic [1:0]           state_dbg
);

    localparam logic [NBITS_WIN-1:0] WSHORT_M1 = NBITS_WIN'(WIN_SHORT - 1);
    localparam logic [NBITS_WIN-1:0] WLONG_M1  = NBITS_WIN'(WIN_LONG - 1);
    localparam logic [2:0]           OFS_SHORT = 3'(REF_OFS_SHORT);
    localparam logic [2:0]           OFS_LONG  = 3'(REF_OFS_LONG);

    gain_mode_e           mode_q;
    gain_state_e          state_q, state_d;
    logic [NBITS_WIN-1:0] hold_q, hold_d;
    logic [NBITS_WIN-1:0] win_m1;
    logic                 sel_q, sel_d;
    logic                 gsw_q;
    logic [2:0]           ref_ofs_q;
    logic                 sat_inc;

    always_comb begin
        win_m1  = (mode_q == MODE_AUTO16) ? WLONG_M1 : WSHORT_M1;
        state_d = state_q;
        hold_d  = hold_q;
        sat_inc = 1'b0;

        case (mode_q)
            MODE_FORCE_G10: begin
                state_d = ST_FORCE_G10;
                hold_d  = '0;
            end
            MODE_FORCE_G1: begin
                state_d = ST_FORCE_G1;
                hold_d  = '0;
            end
            default: begin
                if (state_q == ST_AUTO_G1) begin
                    if (ref_sat) begin
                        // Retrigger: window restarts from the latest saturation.
                        hold_d = win_m1;
                    end else if (hold_q > win_m1) begin
                        // Window shrank (long -> short): clamp, keep x1 this cycle.
                        hold_d = win_m1;
                    end else if (hold_q == '0) begin
                        state_d = ST_AUTO_G10;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end else begin
                    // AUTO_G10, or leaving a forced state: evaluated as AUTO_G10.
                    if (ref_sat) begin
                        state_d = ST_AUTO_G1;
                        hold_d  = win_m1;
                        sat_inc = 1'b1;
                    end else begin
                        state_d = ST_AUTO_G10;
                        hold_d  = '0;
                    end
                end
            end
        endcase

        sel_d = is_g1(state_d);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            mode_q    <= MODE_AUTO8;
            state_q   <= ST_AUTO_G10;
            hold_q    <= '0;
            sel_q     <= 1'b0;
            gsw_q     <= 1'b0;
            ref_ofs_q <= OFS_SHORT;
        end else begin
            mode_q    <= gain_mode_e'(GAIN_SEL_MODE);
            state_q   <= state_d;
            hold_q    <= hold_d;
            sel_q     <= sel_d;
            gsw_q     <= sel_d ^ sel_q;
            ref_ofs_q <= (mode_q == MODE_AUTO16) ? OFS_LONG : OFS_SHORT;
        end
    end

    ldtu_sat_counter #(.WIDTH(NBITS_EVT)) u_sat_events (
        .clk_i (CLK),
        .rst_i (reset),
        .clr_i (cnt_clr),
        .inc_i (sat_inc),
        .cnt_o (sat_events)
    );

    // Counts the registered output, so it trails sel_g1 by one cycle.
    ldtu_sat_counter #(.WIDTH(NBITS_EVT)) u_g1_cycles (
        .clk_i (CLK),
        .rst_i (reset),
        .clr_i (cnt_clr),
        .inc_i (sel_q),
        .cnt_o (g1_cycles)
    );

    assign sel_g1      = sel_q;
    assign gain_switch = gsw_q;
    assign ref_ofs     = ref_ofs_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ldtu_gain_sel_ctrl.sv
// Directed bench for ldtu_gain_sel_ctrl. Cycle n is the clock period whose
// inputs are sampled at rising edge n; outputs are observed 1 ns after an
// edge. A second instance with 4-bit telemetry shares the inputs so that
// counter saturation is reachable in a few cycles.
module tb_ldtu_gain_sel_ctrl;

    logic        CLK = 1'b0;
    logic        reset;
    logic [1:0]  GAIN_SEL_MODE;
    logic        ref_sat;
    logic        cnt_clr;

    logic        sel_g1, gain_switch;
    logic [2:0]  ref_ofs;
    logic [15:0] sat_events, g1_cycles;
    logic [1:0]  state_dbg;

    logic        s_sel_g1, s_gain_switch;
    logic [2:0]  s_ref_ofs;
    logic [3:0]  s_sat_events, s_g1_cycles;
    logic [1:0]  s_state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    ldtu_gain_sel_ctrl dut (
        .CLK           (CLK),
        .reset         (reset),
        .GAIN_SEL_MODE (GAIN_SEL_MODE),
        .ref_sat       (ref_sat),
        .cnt_clr       (cnt_clr),
        .sel_g1        (sel_g1),
        .ref_ofs       (ref_ofs),
        .gain_switch   (gain_switch),
        .sat_events    (sat_events),
        .g1_cycles     (g1_cycles),
        .state_dbg     (state_dbg)
    );

    ldtu_gain_sel_ctrl #(.NBITS_EVT(4)) dut_s (
        .CLK           (CLK),
        .reset         (reset),
        .GAIN_SEL_MODE (GAIN_SEL_MODE),
        .ref_sat       (ref_sat),
        .cnt_clr       (cnt_clr),
        .sel_g1        (s_sel_g1),
        .ref_ofs       (s_ref_ofs),
        .gain_switch   (s_gain_switch),
        .sat_events    (s_sat_events),
        .g1_cycles     (s_g1_cycles),
        .state_dbg     (s_state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        GAIN_SEL_MODE = 2'b00;
        ref_sat       = 1'b0;
        cnt_clr       = 1'b0;
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        // ---- 1: reset state, mode 00, single saturation at cycle 10
        do_reset();
        chk("rst_sel",     32'(sel_g1),        32'd0);
        chk("rst_gsw",     32'(gain_switch),   32'd0);
        chk("rst_sat",     32'(sat_events),    32'd0);
        chk("rst_g1",      32'(g1_cycles),     32'd0);
        chk("rst_state",   32'(state_dbg),     32'd0);
        chk("rst_ofs",     32'(ref_ofs),       32'd3);
        chk("rst_s_sel",   32'(s_sel_g1),      32'd0);
        chk("rst_s_gsw",   32'(s_gain_switch), 32'd0);
        chk("rst_s_sat",   32'(s_sat_events),  32'd0);
        chk("rst_s_g1",    32'(s_g1_cycles),   32'd0);
        chk("rst_s_state", 32'(s_state_dbg),   32'd0);
        chk("rst_s_ofs",   32'(s_ref_ofs),     32'd3);
        while (cyc < 23) begin
            ref_sat = (cyc == 10);
            tick();
            chk("t1_sel", 32'(sel_g1), 32'(cyc >= 11 && cyc <= 18));
            chk("t1_gsw", 32'(gain_switch), 32'(cyc == 11 || cyc == 19));
            if (cyc == 15) chk("t1_state", 32'(state_dbg), 32'd1);
        end
        chk("t1_sat_events", 32'(sat_events), 32'd1);
        chk("t1_g1_cycles",  32'(g1_cycles),  32'd8);
        chk("t1_state_end",  32'(state_dbg),  32'd0);

        // ---- 2: mode 01, saturation at 10 and 20 (retrigger)
        do_reset();
        GAIN_SEL_MODE = 2'b01;
        while (cyc < 40) begin
            ref_sat = (cyc == 10) || (cyc == 20);
            tick();
            if (cyc == 1) chk("t2_ofs_lag", 32'(ref_ofs), 32'd3);
            if (cyc == 2) chk("t2_ofs_long", 32'(ref_ofs), 32'd5);
            chk("t2_sel", 32'(sel_g1), 32'(cyc >= 11 && cyc <= 36));
        end
        chk("t2_sat_events", 32'(sat_events), 32'd1);
        chk("t2_g1_cycles",  32'(g1_cycles),  32'd26);

        // ---- 3: mode 00, saturation at 10, force x10 from cycle 13
        do_reset();
        while (cyc < 26) begin
            ref_sat = (cyc == 10) || (cyc == 20);
            if (cyc == 13) GAIN_SEL_MODE = 2'b10;
            tick();
            chk("t3_sel", 32'(sel_g1), 32'(cyc >= 11 && cyc <= 14));
            chk("t3_gsw", 32'(gain_switch), 32'(cyc == 11 || cyc == 15));
            if (cyc == 16) chk("t3_state", 32'(state_dbg), 32'd2);
        end
        chk("t3_sat_events", 32'(sat_events), 32'd1);

        // ---- 4: force x1 after reset; counter saturation on the 4-bit copy
        do_reset();
        GAIN_SEL_MODE = 2'b11;
        while (cyc < 30) begin
            tick();
            chk("t4_sel", 32'(sel_g1), 32'(cyc >= 2));
            chk("t4_gsw", 32'(gain_switch), 32'(cyc == 2));
            if (cyc == 17) chk("t4_s_g1_full", 32'(s_g1_cycles), 32'd15);
        end
        chk("t4_state",     32'(state_dbg),   32'd3);
        chk("t4_g1_cycles", 32'(g1_cycles),   32'd28);
        chk("t4_s_g1_held", 32'(s_g1_cycles), 32'd15);

        // ---- 5: mode 01, saturation at 10, mode 00 from cycle 12 (clamp), then clear
        do_reset();
        GAIN_SEL_MODE = 2'b01;
        while (cyc < 24) begin
            ref_sat = (cyc == 10);
            if (cyc == 12) GAIN_SEL_MODE = 2'b00;
            tick();
            chk("t5_sel", 32'(sel_g1), 32'(cyc >= 11 && cyc <= 21));
        end
        chk("t5_sat_pre", 32'(sat_events), 32'd1);
        chk("t5_g1_pre",  32'(g1_cycles),  32'd11);
        ref_sat = 1'b1;
        cnt_clr = 1'b1;
        tick();
        chk("t5_sat_clr", 32'(sat_events), 32'd0);
        chk("t5_g1_clr",  32'(g1_cycles),  32'd0);
        chk("t5_sel_new", 32'(sel_g1),     32'd1);
        ref_sat = 1'b0;
        tick();
        chk("t5_g1_clr_inc", 32'(g1_cycles), 32'd0);
        cnt_clr = 1'b0;
        tick();
        chk("t5_g1_resume", 32'(g1_cycles), 32'd1);

        // ---- 6: reset asserted in the middle of a window
        do_reset();
        while (cyc < 15) begin
            ref_sat = (cyc == 10);
            reset   = (cyc == 14);
            tick();
            if (cyc == 14) chk("t6_sel_pre", 32'(sel_g1), 32'd1);
        end
        reset = 1'b0;
        chk("t6_sel",   32'(sel_g1),      32'd0);
        chk("t6_gsw",   32'(gain_switch), 32'd0);
        chk("t6_state", 32'(state_dbg),   32'd0);
        chk("t6_sat",   32'(sat_events),  32'd0);
        chk("t6_g1",    32'(g1_cycles),   32'd0);
        tick();
        chk("t6_gsw_after", 32'(gain_switch), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
